// File: rtl/deserializer.sv
// Serial-to-parallel converter: collects data_i bits MSB-first into a
// WIDTH-bit word and presents completed words through a one-entry
// valid/ready output register. A word that completes while the output
// register is held (FULL, ready low) is dropped and flagged on overflow_o.
module deserializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             data_i,
    input  logic             data_val_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic             deser_data_val_o,
    input  logic             deser_data_ready_i,
    output logic             overflow_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             word_done;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic             overflow_q;

    // A word completes when the bit for the last slot is being taken.
    assign word_done = data_val_i && (cnt_q == LAST_CNT);

    // Bit counter: advance on each qualified bit, wrap after the last slot.
    always_comb begin
        cnt_d = cnt_q;
        if (data_val_i) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Each shift-register bit captures data_i only when the counter points at
    // its slot; the first bit of a word lands in the MSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
            localparam logic [CW-1:0] SLOT = CW'(WIDTH - 1 - gi);
            assign shift_d[gi] = (data_val_i && (cnt_q == SLOT)) ? data_i : shift_q[gi];
        end
    endgenerate

    // Serial collection state; runs regardless of the output stage.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Output stage FSM. shift_d already contains the final bit on the
    // completion cycle, so it is the complete word to load.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q    <= EMPTY;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            case (state_q)
                EMPTY: begin
                    if (word_done) begin
                        data_q  <= shift_d;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (deser_data_ready_i) begin
                        if (word_done) begin
                            data_q <= shift_d;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end else if (word_done) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_val_o = (state_q == FULL);
    assign overflow_o       = overflow_q;

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter: WIDTH, default 16, output word width in bits; legal range 2..64.
REQ-002 Port: clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 Port: srst_i  input  1  synchronous reset, active-low (0 = reset, sampled on clk_i).
REQ-004 Port: data_i  input  1  serial data bit.
REQ-005 Port: data_val_i  input  1  qualifies data_i; the bit is consumed only when 1.
REQ-006 Port: deser_data_o  output  WIDTH  assembled parallel word.
REQ-007 Port: deser_data_val_o  output  1  deser_data_o holds a valid word.
REQ-008 Port: deser_data_ready_i  input  1  downstream accepts the word when high together with deser_data_val_o.
REQ-009 Port: overflow_o  output  1  one-cycle pulse: a completed word was dropped.

Function
REQ-010 The block SHALL keep a bit counter, 0..WIDTH-1, width $clog2(WIDTH), advancing by 1 on each cycle with data_val_i=1 and wrapping from WIDTH-1 to 0.
REQ-011 The block SHALL place bits MSB-first: the bit taken at counter value k goes to shift-register bit WIDTH-1-k.
REQ-012 Cycles with data_val_i=0 SHALL leave the counter and shift register unchanged; gaps of any length are legal.
REQ-013 The word SHALL complete on the cycle the bit at counter WIDTH-1 is taken ("completion").
REQ-014 The output stage SHALL be a two-state FSM: EMPTY (deser_data_val_o=0) and FULL (deser_data_val_o=1).
REQ-015 In EMPTY, completion SHALL load deser_data_o with the full word, including the final bit, and move to FULL; deser_data_val_o SHALL be 1 on the cycle after the final bit is sampled (latency 1).
REQ-016 In FULL with deser_data_ready_i=1 and no completion, the word SHALL be transferred and the FSM SHALL move to EMPTY.
REQ-017 In FULL with deser_data_ready_i=1 and completion in the same cycle, deser_data_o SHALL load the new word and the FSM SHALL stay FULL, so deser_data_val_o stays 1 with no bubble.
REQ-018 In FULL with deser_data_ready_i=0 and completion, the new word SHALL be dropped, deser_data_o SHALL keep its value, and overflow_o SHALL be 1 for exactly the next cycle.
REQ-019 In FULL with deser_data_ready_i=0, deser_data_o SHALL be stable.
REQ-020 Serial collection SHALL continue whatever the FSM state; the shift register is independent of the output register.
REQ-021 deser_data_ready_i SHALL be ignored in EMPTY.
REQ-022 deser_data_o SHALL change only on a load (REQ-015, REQ-017).

Reset
REQ-023 While srst_i=0: deser_data_o=0, deser_data_val_o=0, overflow_o=0, counter=0, shift register=0, FSM=EMPTY; all outputs take these values on the cycle after srst_i is sampled low.
REQ-024 A reset in mid-word SHALL discard the partial word; the first qualified bit after srst_i returns to 1 SHALL be counter value 0.
REQ-025 A reset while FULL SHALL discard the held word without a transfer.
REQ-026 Inputs sampled in the same cycle that srst_i=0 SHALL be ignored.

Verification (WIDTH=8)
REQ-027 Bits 1,0,1,1,0,0,1,0 on consecutive cycles with data_val_i=1 and ready=1 -> deser_data_o=8'hB2 and deser_data_val_o=1 on the cycle after the 8th bit, then 0.
REQ-028 Same bits with data_val_i=0 for 3 cycles after bits 2 and 5 -> deser_data_o=8'hB2, valid 1 cycle after the last qualified bit.
REQ-029 ready=0, send 8'hB2 then 8'h0F -> val stays 1, deser_data_o=8'hB2, and overflow_o pulses once on the cycle after the 8th bit of 8'h0F; then ready=1 -> one transfer of 8'hB2 and val returns to 0.
REQ-030 Stream 8'hA5,8'h3C back-to-back with ready=1 on the completion cycle -> val stays 1 with no gap, deser_data_o goes 8'hA5 then 8'h3C, and overflow_o stays 0.
REQ-031 srst_i=0 after 4 bits, then 8 bits of 8'hC3 -> deser_data_o=8'hC3, with no residue from the first 4 bits.
REQ-032 srst_i=0 while FULL -> val=0 and deser_data_o=0 the next cycle, and no overflow_o pulse.
